dmem_unit: RTL

Data-memory stage directly downstream of the single-cycle core's data port. Consumes `address`, `write_data`, `MemWrite` and `MemRead` plus the instruction's funct3, and returns `read_data` in the same cycle. Provides byte, half and word loads and stores on a word-organised RAM, detects misaligned accesses, and optionally exposes a small memory-mapped I/O region (GPIO register, free-running cycle counter, status).

---
 rtl/dmem_pkg.sv | 65 ++++++
 rtl/dmem_lane.sv | 38 +++
 rtl/dmem_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types, MMIO address map and decode helpers for the data-memory stage.
package dmem_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_f3_e;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_f3_e;

    typedef enum logic [1:0] {ACC_B, ACC_H, ACC_W} acc_w_e;

    typedef enum logic [2:0] {
        RGN_RAM, RGN_GPIO, RGN_CYCLE, RGN_STATUS, RGN_NONE
    } region_e;

    localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;
    localparam logic [31:0] GPIO_ADDR   = MMIO_BASE + 32'h0;
    localparam logic [31:0] CYCLE_ADDR  = MMIO_BASE + 32'h4;
    localparam logic [31:0] STATUS_ADDR = MMIO_BASE + 32'h8;

    function automatic acc_w_e load_width(input logic [2:0] f3);
        case (f3)
            LB, LBU: return ACC_B;
            LH, LHU: return ACC_H;
            default: return ACC_W;
        endcase
    endfunction

    function automatic acc_w_e store_width(input logic [2:0] f3);
        case (f3)
            SB:      return ACC_B;
            SH:      return ACC_H;
            default: return ACC_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input acc_w_e w, input logic [1:0] off);
        case (w)
            ACC_H:   return off[0];
            ACC_W:   return |off;
            default: return 1'b0;
        endcase
    endfunction

    // MMIO registers decode on the word address; width checks happen at the use site.
    function automatic region_e decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes);
        if (addr < ram_bytes) return RGN_RAM;
        case ({addr[31:2], 2'b00})
            GPIO_ADDR:   return RGN_GPIO;
            CYCLE_ADDR:  return RGN_CYCLE;
            STATUS_ADDR: return RGN_STATUS;
            default:     return RGN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Combinational load extraction/extension and store byte-merge for one RAM word.
module dmem_lane
    import dmem_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [2:0]   funct3,
    input  logic [1:0]   byte_off,
    input  logic [W-1:0] rd_word,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] load_val,
    output logic [W-1:0] store_word
);

    logic [W-1:0] shifted;

    always_comb begin
        shifted  = rd_word >> {byte_off, 3'b000};
        load_val = rd_word;
        case (funct3)
            LB:      load_val = {{(W-8){shifted[7]}}, shifted[7:0]};
            LBU:     load_val = {{(W-8){1'b0}}, shifted[7:0]};
            LH:      load_val = {{(W-16){shifted[15]}}, shifted[15:0]};
            LHU:     load_val = {{(W-16){1'b0}}, shifted[15:0]};
            default: load_val = rd_word;
        endcase
    end

    always_comb begin
        store_word = rd_word;
        case (funct3)
            SB:      store_word[{byte_off, 3'b000} +: 8]         = wr_data[7:0];
            SH:      store_word[{byte_off[1], 4'b0000} +: 16]    = wr_data[15:0];
            default: store_word = wr_data;
        endcase
    end

endmodule

// File: rtl/dmem_unit.sv
// Data-memory stage: word RAM, sub-word access, misalign flag and optional MMIO
// region (GPIO, CYCLE, STATUS) enabled by DMEM_MMIO_EN.
module dmem_unit
    import dmem_pkg::*;
#(
    parameter int size      = 32,
    parameter int mem_depth = 1024
) (
    input  logic            CLK,
    input  logic            RSTa,
    input  logic [size-1:0] address,
    input  logic [size-1:0] write_data,
    input  logic            MemWrite,
    input  logic            MemRead,
    input  logic [2:0]      funct3,
    output logic [size-1:0] read_data,
    output logic [size-1:0] gpio_out,
    output logic            misalign
);

    localparam int ADDR_W = $clog2(mem_depth);

    logic [size-1:0]   ram_q [mem_depth];
    logic [ADDR_W-1:0] word_idx;
    logic [size-1:0]   rd_word, load_val, store_word, ram_wdata_d;
    acc_w_e            ld_w, st_w;
    region_e           rgn;
    logic              ld_mis, st_mis, st_ok, ram_we_d;
    logic              misalign_d, misalign_q;

    assign word_idx = address[ADDR_W+1:2];
    assign rd_word  = ram_q[word_idx];
    assign ld_w     = load_width(funct3);
    assign st_w     = store_width(funct3);
    assign ld_mis   = MemRead  && is_misaligned(ld_w, address[1:0]);
    assign st_mis   = MemWrite && is_misaligned(st_w, address[1:0]);
    assign st_ok    = MemWrite && !st_mis;
    assign rgn      = decode_region(address, 32'(mem_depth * 4));

    dmem_lane #(.W(size)) u_lane (
        .funct3     (funct3),
        .byte_off   (address[1:0]),
        .rd_word    (rd_word),
        .wr_data    (write_data),
        .load_val   (load_val),
        .store_word (store_word)
    );

    always_comb begin
        ram_we_d    = st_ok && (rgn == RGN_RAM);
        ram_wdata_d = store_word;
    end

    // Stores in a reset cycle are dropped; RAM contents survive reset.
    always_ff @(posedge CLK) begin
        if (ram_we_d && !RSTa) ram_q[word_idx] <= ram_wdata_d;
    end

`ifdef DMEM_MMIO_EN
    logic [size-1:0] gpio_d, gpio_q, cycle_d, cycle_q;
    logic            status_clr;

    always_comb begin
        gpio_d     = gpio_q;
        cycle_d    = cycle_q + 1'b1;
        status_clr = st_ok && (st_w == ACC_W) && (rgn == RGN_STATUS);
        if (st_ok && (st_w == ACC_W) && (rgn == RGN_GPIO)) gpio_d = write_data;
    end

    always_ff @(posedge CLK) begin
        if (RSTa) begin
            gpio_q  <= '0;
            cycle_q <= '0;
        end else begin
            gpio_q  <= gpio_d;
            cycle_q <= cycle_d;
        end
    end

    assign gpio_out = gpio_q;
`else
    assign gpio_out = '0;
`endif

    // A new misaligned access outranks a STATUS clear in the same cycle.
    always_comb begin
        misalign_d = misalign_q;
`ifdef DMEM_MMIO_EN
        if (status_clr) misalign_d = 1'b0;
`endif
        if (ld_mis || st_mis) misalign_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RSTa) misalign_q <= 1'b0;
        else      misalign_q <= misalign_d;
    end

    assign misalign = misalign_q;

    always_comb begin
        read_data = '0;
        if (MemRead && !ld_mis) begin
            case (rgn)
                RGN_RAM:    read_data = load_val;
`ifdef DMEM_MMIO_EN
                RGN_GPIO:   if (ld_w == ACC_W) read_data = gpio_q;
                RGN_CYCLE:  if (ld_w == ACC_W) read_data = cycle_q;
                RGN_STATUS: if (ld_w == ACC_W) read_data = {{(size-1){1'b0}}, misalign_q};
`endif
                default:    read_data = '0;
            endcase
        end
    end

endmodule
